// File: rtl/resp_pack_pkg.sv
// Shared defaults, state encoding and line type for the response line packer.
package resp_pkg;
  localparam int RESP_WORD_W    = 32;
  localparam int RESP_NUM_SLOTS = 8;
  localparam int RESP_LINE_W    = RESP_WORD_W * RESP_NUM_SLOTS;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef struct packed {
    logic [RESP_LINE_W-1:0]    data;
    logic [RESP_NUM_SLOTS-1:0] mask;
  } resp_line_t;
endpackage

// File: rtl/resp_pack_if.sv
// Word-in / line-out handshake bundle for resp_pack.
interface resp_pack_if
  import resp_pkg::*;
#(
  parameter int WORD_W    = RESP_WORD_W,
  parameter int NUM_SLOTS = RESP_NUM_SLOTS,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
);
  logic                        in_vld;
  logic                        in_rdy;
  logic [IDX_W-1:0]            in_idx;
  logic [WORD_W-1:0]           in_data;
  logic                        in_last;
  logic                        out_vld;
  logic                        out_rdy;
  logic [NUM_SLOTS*WORD_W-1:0] out_data;
  logic [NUM_SLOTS-1:0]        out_mask;
  logic                        dup_err;

  modport master (
    output in_vld, in_idx, in_data, in_last, out_rdy,
    input  in_rdy, out_vld, out_data, out_mask, dup_err
  );

  modport slave (
    input  in_vld, in_idx, in_data, in_last, out_rdy,
    output in_rdy, out_vld, out_data, out_mask, dup_err
  );
endinterface

// File: rtl/resp_pack_slot_wr.sv
// Slot-index decode and merge of one word into the line; optional clear of the old line first.
module resp_slot_wr
  import resp_pkg::*;
#(
  parameter int WORD_W    = RESP_WORD_W,
  parameter int NUM_SLOTS = RESP_NUM_SLOTS,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0][WORD_W-1:0] line_i,
  input  logic [NUM_SLOTS-1:0]             mask_i,
  input  logic                             clr_i,
  input  logic                             we_i,
  input  logic [IDX_W-1:0]                 idx_i,
  input  logic [WORD_W-1:0]                data_i,
  output logic [NUM_SLOTS-1:0][WORD_W-1:0] line_o,
  output logic [NUM_SLOTS-1:0]             mask_o,
  output logic                             hit_o
);
  // A cleared line has no filled slots, so a clear masks the duplicate check too.
  assign hit_o = we_i && !clr_i && mask_i[idx_i];

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    logic sel;
    assign sel       = we_i && (idx_i == IDX_W'(k));
    assign line_o[k] = sel ? data_i : (clr_i ? '0 : line_i[k]);
    assign mask_o[k] = sel | (!clr_i & mask_i[k]);
  end
endmodule

// File: rtl/resp_pack.sv
// Packs slot-addressed words into one wide line; emits on full mask or in_last.
module resp_pack
  import resp_pkg::*;
#(
  parameter int WORD_W    = RESP_WORD_W,
  parameter int NUM_SLOTS = RESP_NUM_SLOTS,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input logic        clk,
  input logic        rst,
  resp_pack_if.slave bus
);
  state_e                           state_q;
  logic [NUM_SLOTS-1:0][WORD_W-1:0] data_q, data_d;
  logic [NUM_SLOTS-1:0]             mask_q, mask_d;
  logic                             dup_q, hit;
  logic                             accept, drain;

  // in_rdy looks straight through to out_rdy so a draining line never costs a bubble.
  assign bus.in_rdy = (state_q == FILL) || bus.out_rdy;
  assign accept     = bus.in_vld && bus.in_rdy;
  assign drain      = (state_q == FULL) && bus.out_rdy;

  resp_slot_wr #(.WORD_W(WORD_W), .NUM_SLOTS(NUM_SLOTS)) u_slot_wr (
    .line_i (data_q),
    .mask_i (mask_q),
    .clr_i  (drain),
    .we_i   (accept),
    .idx_i  (bus.in_idx),
    .data_i (bus.in_data),
    .line_o (data_d),
    .mask_o (mask_d),
    .hit_o  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      data_q  <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      dup_q <= hit;
      // Accept in FULL only happens alongside a drain, so FULL otherwise holds.
      if (accept || drain) begin
        data_q  <= data_d;
        mask_q  <= mask_d;
        state_q <= (accept && ((&mask_d) || bus.in_last)) ? FULL : FILL;
      end
    end
  end

  assign bus.out_vld  = (state_q == FULL);
  assign bus.out_data = data_q;
  assign bus.out_mask = mask_q;
  assign bus.dup_err  = dup_q;
endmodule

// File: tb/tb_resp_pack.sv
// Directed bench for resp_pack with a line scoreboard checked on every drain.
module tb_resp_pack;
  import resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  resp_pack_if #(.WORD_W(32), .NUM_SLOTS(8)) bus ();

  resp_pack #(.WORD_W(32), .NUM_SLOTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  resp_line_t              sbq[$];
  logic [7:0][31:0]        mdata;
  logic [7:0]              mmask;
  resp_line_t              last_line;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mdata = '0;
    mmask = '0;
  endtask

  task automatic model_apply(input logic [2:0] idx, input logic [31:0] d, input logic last);
    mdata[idx] = d;
    mmask[idx] = 1'b1;
    if ((&mmask) || last) begin
      last_line.data = mdata;
      last_line.mask = mmask;
      sbq.push_back(last_line);
      model_clear();
    end
  endtask

  // Drives one word and returns #1 after the edge that accepted it.
  task automatic put(input logic [2:0] idx, input logic [31:0] d, input logic last);
    bit ok = 0;
    bus.in_vld  = 1'b1;
    bus.in_idx  = idx;
    bus.in_data = d;
    bus.in_last = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("rdy_timeout", 256'(0), 256'(1));
    @(posedge clk);
    #1;
    if (ok) model_apply(idx, d, last);
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      if (sbq.size() == 0) begin
        chk("extra_line", 256'(1), 256'(0));
      end else begin
        resp_line_t e;
        e = sbq.pop_front();
        chk("line_data", bus.out_data, e.data);
        chk("line_mask", 256'(bus.out_mask), 256'(e.mask));
      end
    end
  end

  initial begin
    int c0;
    bus.in_vld  = 1'b0;
    bus.in_idx  = '0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b1;
    model_clear();

    step();
    step();
    chk("rst_vld",  256'(bus.out_vld),  256'(0));
    chk("rst_mask", 256'(bus.out_mask), 256'(0));
    chk("rst_data", bus.out_data,       256'(0));
    chk("rst_dup",  256'(bus.dup_err),  256'(0));
    rst = 1'b0;
    step();
    chk("idle_rdy", 256'(bus.in_rdy), 256'(1));

    // ordered fill
    for (int i = 0; i < 8; i++) begin
      put(3'(i), 32'h100 + i, 1'b0);
      chk("fill_vld", 256'(bus.out_vld), 256'(i == 7));
    end
    chk("fill_lo",   256'(bus.out_data[31:0]),    256'(32'h100));
    chk("fill_hi",   256'(bus.out_data[255:224]), 256'(32'h107));
    chk("fill_mask", 256'(bus.out_mask),          256'(8'hFF));
    step();
    chk("fill_drained", 256'(bus.out_vld), 256'(0));

    // out-of-order early close, then in_last on an empty buffer
    put(3'd5, 32'hAAAA, 1'b0);
    put(3'd2, 32'hBBBB, 1'b1);
    chk("early_vld",  256'(bus.out_vld),  256'(1));
    chk("early_mask", 256'(bus.out_mask), 256'(8'h24));
    chk("early_data", bus.out_data, (256'h0000AAAA << 160) | (256'h0000BBBB << 64));
    step();
    put(3'd6, 32'h66, 1'b1);
    chk("one_word_mask", 256'(bus.out_mask), 256'(8'h40));
    step();

    // backpressure with a stalled producer holding a word
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) put(3'(i), 32'h200 + i, 1'b0);
    bus.in_vld  = 1'b1;
    bus.in_idx  = 3'd0;
    bus.in_data = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rdy",  256'(bus.in_rdy),  256'(0));
      chk("bp_vld",  256'(bus.out_vld), 256'(1));
      chk("bp_data", bus.out_data,      last_line.data);
      step();
    end
    bus.out_rdy = 1'b1;
    bus.in_idx  = 3'd3;
    bus.in_data = 32'h33;
    bus.in_last = 1'b0;
    step();
    model_apply(3'd3, 32'h33, 1'b0);
    bus.in_vld = 1'b0;
    chk("bp_next_vld",  256'(bus.out_vld),  256'(0));
    chk("bp_next_mask", 256'(bus.out_mask), 256'(8'h08));
    chk("bp_next_data", bus.out_data,       256'h33 << 96);
    put(3'd4, 32'h44, 1'b1);
    chk("bp_close_mask", 256'(bus.out_mask), 256'(8'h18));
    step();

    // back-to-back lines
    c0 = cyc;
    for (int j = 0; j < 16; j++) begin
      put(3'(j % 8), 32'h400 + j, 1'b0);
      chk("b2b_vld", 256'(bus.out_vld), 256'(j == 7 || j == 15));
    end
    chk("b2b_cycles", 256'(cyc - c0), 256'(16));
    step();

    // duplicate slot
    put(3'd1, 32'h11, 1'b0);
    chk("dup_first", 256'(bus.dup_err), 256'(0));
    put(3'd1, 32'h22, 1'b0);
    chk("dup_pulse", 256'(bus.dup_err),          256'(1));
    chk("dup_slot",  256'(bus.out_data[63:32]),  256'(32'h22));
    chk("dup_mask",  256'(bus.out_mask),         256'(8'h02));
    chk("dup_vld",   256'(bus.out_vld),          256'(0));
    step();
    chk("dup_once",  256'(bus.dup_err), 256'(0));

    // reset mid-line
    put(3'd4, 32'h44, 1'b0);
    put(3'd5, 32'h55, 1'b0);
    put(3'd6, 32'h66, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    chk("mrst_vld",  256'(bus.out_vld),  256'(0));
    chk("mrst_mask", 256'(bus.out_mask), 256'(0));
    chk("mrst_data", bus.out_data,       256'(0));
    for (int i = 7; i >= 0; i--) put(3'(i), 32'h300 + i, 1'b0);
    chk("post_rst_mask", 256'(bus.out_mask), 256'(8'hFF));
    step();
    step();
    chk("sb_empty", 256'(sbq.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
